// File: rtl/perip_pwm_cap_pkg.sv
// Shared definitions for the PWM input-capture peripheral.
//   cap_state_e : capture FSM states
//   CNT_W       : width of the cycle counter and measurement outputs
//   CNT_SAT     : saturation value of the cycle counter
//   sat_inc()   : increment that sticks at CNT_SAT instead of wrapping
package perip_pwm_cap_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } cap_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/perip_sync_filt.sv
// Pin input conditioner: SYNC_STAGES-flop synchronizer followed by an
// optional stability filter. Reusable for any slow asynchronous pin.
// Optional feature macro: PWM_CAP_GLITCH_FILT_EN (filter compiled in when
// defined; otherwise the output is the synchronized level and FILT_LEN is
// unused).
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   pin    in  asynchronous pin
//   level  out conditioned (filtered) level, resets to 0
module perip_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILT_EN
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [FW-1:0] stab_q;
  logic          filt_q;

  // stab_q counts consecutive cycles the synchronized level has disagreed
  // with the filtered level; the filtered level follows only after
  // FILT_LEN such cycles in a row, so both edges are delayed equally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
      filt_q <= 1'b0;
    end else if (sync_lvl == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == FW'(FILT_LEN - 1)) begin
      stab_q <= '0;
      filt_q <= sync_lvl;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_lvl;
`endif

endmodule

// File: rtl/perip_pwm_capture.sv
// PWM input-capture peripheral: measures period (rise to rise) and high
// time (rise to fall) of an external PWM pin, in clock cycles.
// Optional feature macro: PWM_CAP_GLITCH_FILT_EN (glitch filter in the
// input conditioner).
// Ports:
//   CLK, RST_n    clock, asynchronous active-low reset
//   PWM_In        asynchronous PWM pin
//   Cap_En        capture enable (level)
//   Timeout_Set   stall limit in cycles, 0 disables
//   Period_Out    last measured period
//   High_Out      last measured high time
//   Cap_Valid     one-cycle pulse when Period_Out/High_Out update
//   Cap_Stall     sticky: no edge seen within Timeout_Set
//   Level_Out     current filtered pin level
//
// state | meaning
// IDLE  | capture off, counter held at 0
// ARM   | waiting for a low level, then the first rise (not published)
// HIGH  | counting the high phase since the last accepted rise
// LOW   | counting the low phase; next rise publishes a measurement
module perip_pwm_capture
  import perip_pwm_cap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             PWM_In,
  input  logic             Cap_En,
  input  logic [CNT_W-1:0] Timeout_Set,
  output logic [CNT_W-1:0] Period_Out,
  output logic [CNT_W-1:0] High_Out,
  output logic             Cap_Valid,
  output logic             Cap_Stall,
  output logic             Level_Out
);

  logic             lvl, lvl_prev, rise, fall;
  cap_state_e       state_q, state_d;
  logic             seen_low_q, en_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc, high_q;
  logic             timeout;
  logic             arm_rise, fall_hit, publish, stall_set;

  perip_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sync_filt (
    .clk  (CLK),
    .rst_n(RST_n),
    .pin  (PWM_In),
    .level(lvl)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) lvl_prev <= 1'b0;
    else        lvl_prev <= lvl;
  end

  assign rise      = lvl & ~lvl_prev;
  assign fall      = ~lvl & lvl_prev;
  assign Level_Out = lvl;

  // The counter reads 0 in the cycle after the rise, so "cycles since the
  // rise" seen on an edge is one more than the counter value.
  assign cnt_inc = sat_inc(cnt_q);
  assign timeout = (Timeout_Set != '0) && (cnt_q >= Timeout_Set);

  always_comb begin
    state_d   = state_q;
    arm_rise  = 1'b0;
    fall_hit  = 1'b0;
    publish   = 1'b0;
    stall_set = 1'b0;
    if (!Cap_En) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise && seen_low_q) begin
            state_d  = HIGH;
            arm_rise = 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d  = LOW;
            fall_hit = 1'b1;
          end else if (timeout) begin
            state_d   = ARM;
            stall_set = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_d = HIGH;
            publish = 1'b1;
          end else if (timeout) begin
            state_d   = ARM;
            stall_set = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      seen_low_q <= 1'b0;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      high_q     <= '0;
      Period_Out <= '0;
      High_Out   <= '0;
      Cap_Valid  <= 1'b0;
      Cap_Stall  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= Cap_En;

      // Only a low level observed while already armed qualifies a rise;
      // this rejects a pin that is high when capture starts.
      if (state_q == ARM && state_d == ARM) seen_low_q <= seen_low_q | ~lvl;
      else                                  seen_low_q <= 1'b0;

      if ((state_d == HIGH || state_d == LOW) && !arm_rise && !publish)
        cnt_q <= cnt_inc;
      else
        cnt_q <= '0;

      if (fall_hit) high_q <= cnt_inc;

      if (publish) begin
        Period_Out <= cnt_inc;
        High_Out   <= high_q;
      end
      Cap_Valid <= publish;

      if (publish || (Cap_En && !en_q)) Cap_Stall <= 1'b0;
      else if (stall_set)               Cap_Stall <= 1'b1;
    end
  end

endmodule
